// File: rtl/common_types_pkg.sv
// Shared types for the front-end playback block: UART receiver and
// playback FSM state encodings plus the UART character width.
package common_types_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_rx_state_t;

    typedef enum logic [1:0] {
        P_IDLE,
        P_FILL,
        P_PLAY
    } play_state_t;

endpackage : common_types_pkg

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchroniser followed by a mid-bit
// sampling FSM. Emits one-cycle rx_valid / rx_frame_err pulses.
module uart_rx
    import common_types_pkg::*;
#(
    parameter int CLKS_PER_BIT = 20
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rxd_async_i,
    output logic [UART_DATA_BITS-1:0] rx_byte,
    output logic                      rx_valid,
    output logic                      rx_frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(UART_DATA_BITS);

    localparam logic [CNT_W-1:0] HALF_BIT_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_BIT_IDX  = IDX_W'(UART_DATA_BITS - 1);

    logic                      rxd_meta_q;
    logic                      rxd_sync_q;
    uart_rx_state_t            state_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [IDX_W-1:0]          bit_idx_q;
    logic [UART_DATA_BITS-1:0] shreg_q;
    logic [UART_DATA_BITS-1:0] rx_byte_q;
    logic                      rx_valid_q;
    logic                      rx_frame_err_q;

    // Bring the asynchronous line into the clk domain; idles high so reset does not fake a start bit.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
        end else begin
            rxd_meta_q <= rxd_async_i;
            rxd_sync_q <= rxd_meta_q;
        end
    end

    // Frame FSM: qualify the start bit at half a bit, then sample data and stop at mid-bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            bit_idx_q      <= '0;
            shreg_q        <= '0;
            rx_byte_q      <= '0;
            rx_valid_q     <= 1'b0;
            rx_frame_err_q <= 1'b0;
        end else begin
            rx_valid_q     <= 1'b0;
            rx_frame_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (!rxd_sync_q) begin
                        state_q <= START;
                    end
                end
                START: begin
                    if (cnt_q == HALF_BIT_LAST) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        // A line that has gone high again was a glitch, not a start bit.
                        state_q   <= rxd_sync_q ? IDLE : DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == FULL_BIT_LAST) begin
                        cnt_q   <= '0;
                        shreg_q <= {rxd_sync_q, shreg_q[UART_DATA_BITS-1:1]};
                        if (bit_idx_q == LAST_BIT_IDX) begin
                            state_q <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_q == FULL_BIT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                        if (rxd_sync_q) begin
                            rx_byte_q  <= shreg_q;
                            rx_valid_q <= 1'b1;
                        end else begin
                            rx_frame_err_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx_byte      = rx_byte_q;
    assign rx_valid     = rx_valid_q;
    assign rx_frame_err = rx_frame_err_q;

endmodule : uart_rx

// File: rtl/fem_playback.sv
// Front-end playback: UART bytes are buffered in a byte FIFO and replayed
// LSB-first as a 1-bit sample stream at one sample per SAMPLE_DIV clocks.
module fem_playback
    import common_types_pkg::*;
#(
    parameter int CLKS_PER_BIT = 20,
    parameter int SAMPLE_DIV   = 25,
    parameter int FIFO_DEPTH   = 64,
    parameter int PREFILL      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        uart_rxd,
    input  logic                        play_en,
    output logic                        sample_o,
    output logic                        sample_stb,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        underflow,
    output logic                        overflow,
    output logic                        frame_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    localparam logic [LVL_W-1:0] LVL_FULL    = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] LVL_PREFILL = LVL_W'(PREFILL);
    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(SAMPLE_DIV - 1);

    // Receiver
    logic [UART_DATA_BITS-1:0] rx_byte;
    logic                      rx_valid;
    logic                      rx_frame_err;

    uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_rx (
        .clk          (clk),
        .rst          (rst),
        .rxd_async_i  (uart_rxd),
        .rx_byte      (rx_byte),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err)
    );

    // FIFO state
    logic [UART_DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]          level_q, level_d;
    logic                      overflow_q, frame_err_q;
    logic                      fifo_full, fifo_empty, push, pop;
    logic [UART_DATA_BITS-1:0] rd_data;

    // Playback state
    play_state_t               state_q;
    logic [DIV_W-1:0]          div_q;
    logic [UART_DATA_BITS-1:0] shreg_q;
    logic [3:0]                bit_cnt_q;
    logic                      sample_q, stb_q, underflow_q;
    logic                      tick;

    assign rd_data = mem[rd_ptr_q];

    // FIFO control and pointer next-state; pop requests come from the playback FSM conditions.
    // NOTE: every signal gets a default at the top so no path through the block can infer a latch.
    always_comb begin
        fifo_full  = (level_q == LVL_FULL);
        fifo_empty = (level_q == '0);
        tick       = (state_q == P_PLAY) && (div_q == DIV_LAST);
        push       = rx_valid && !fifo_full;
        pop        = 1'b0;
        if (play_en) begin
            if (state_q == P_FILL && level_q >= LVL_PREFILL) begin
                pop = 1'b1;
            end else if (tick && bit_cnt_q == 4'd1 && !fifo_empty) begin
                pop = 1'b1;
            end
        end
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q;
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push) begin
            level_d = level_q - 1'b1;
        end
    end

    // FIFO pointers, level and the sticky receive-side flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            if (rx_valid && fifo_full) begin
                overflow_q <= 1'b1;
            end
            if (rx_frame_err) begin
                frame_err_q <= 1'b1;
            end
        end
    end

    // FIFO storage write port.
    // NOTE: the storage array has no reset; the pointers and level decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= rx_byte;
        end
    end

    // Playback FSM: prefill, then shift one sample out per tick and refill the shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= P_IDLE;
            div_q       <= '0;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            sample_q    <= 1'b0;
            stb_q       <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            stb_q <= 1'b0;
            if (!play_en) begin
                state_q   <= P_IDLE;
                div_q     <= '0;
                shreg_q   <= '0;
                bit_cnt_q <= '0;
            end else begin
                case (state_q)
                    P_IDLE: begin
                        state_q <= P_FILL;
                    end
                    P_FILL: begin
                        div_q <= '0;
                        if (pop) begin
                            shreg_q   <= rd_data;
                            bit_cnt_q <= 4'd8;
                            state_q   <= P_PLAY;
                        end
                    end
                    P_PLAY: begin
                        if (tick) begin
                            div_q    <= '0;
                            sample_q <= shreg_q[0];
                            stb_q    <= 1'b1;
                            if (bit_cnt_q == 4'd1) begin
                                if (pop) begin
                                    shreg_q   <= rd_data;
                                    bit_cnt_q <= 4'd8;
                                end else begin
                                    // Starved: sample_o keeps its last value while we refill.
                                    underflow_q <= 1'b1;
                                    bit_cnt_q   <= '0;
                                    state_q     <= P_FILL;
                                end
                            end else begin
                                shreg_q   <= {1'b0, shreg_q[UART_DATA_BITS-1:1]};
                                bit_cnt_q <= bit_cnt_q - 4'd1;
                            end
                        end else begin
                            div_q <= div_q + 1'b1;
                        end
                    end
                    default: state_q <= P_IDLE;
                endcase
            end
        end
    end

    assign sample_o   = sample_q;
    assign sample_stb = stb_q;
    assign fifo_level = level_q;
    assign underflow  = underflow_q;
    assign overflow   = overflow_q;
    assign frame_err  = frame_err_q;

endmodule : fem_playback
